// File: rtl/ser_in_par_out_if.sv
// Serial word link receive-side bundle: serial bit stream in, ready/valid word out.
interface ser_in_par_out_if #(
  parameter int unsigned WIDTH = 16
);

  logic             din;
  logic             din_en;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;

  // Bit source / word consumer side
  modport master (
    output din,
    output din_en,
    output sof,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  overrun
  );

  // Deserializer side
  modport slave (
    input  din,
    input  din_en,
    input  sof,
    input  dout_ready,
    output dout,
    output dout_valid,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/ser_in_par_out.sv
// LSB-first serial-in parallel-out deserializer with sof framing, one-word
// ready/valid output slot, and registered frame_err / overrun pulses.
module ser_in_par_out #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ser_in_par_out_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] word_c;
  logic             word_done_c;
  logic             slot_free_c;

  // Shift register contents after taking the current bit in at the MSB end
  assign word_c = {bus.din, sh_q[WIDTH-1:1]};

  // State register plus shifter, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state: framing, bit counting and word completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    word_done_c = 1'b0;
    frame_err_d = 1'b0;
    if (bus.din_en) begin
      case (state_q)
        IDLE: begin
          // Bits outside a frame are ignored until a sof arrives
          if (bus.sof) begin
            sh_d    = word_c;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sh_d = word_c;
          if (bus.sof) begin
            // Resync: stale bits are shifted out before the new word completes
            cnt_d       = CW'(1);
            frame_err_d = 1'b1;
          end else if (cnt_q == LAST_BIT) begin
            cnt_d       = '0;
            state_d     = IDLE;
            word_done_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output slot: load on free slot, otherwise drop word and flag overrun
  always_comb begin
    slot_free_c  = !dout_valid_q || bus.dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !bus.dout_ready;
    overrun_d    = 1'b0;
    if (word_done_c) begin
      if (slot_free_c) begin
        dout_d       = word_c;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ser_in_par_out.sv
// Directed bench for ser_in_par_out: framing, resync, overrun, handshake, reset.
module tb_ser_in_par_out;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;

  int checks;
  int failures;
  int fe_cnt;
  int ov_cnt;

  ser_in_par_out_if #(.WIDTH(WIDTH)) bus ();

  ser_in_par_out #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample at the following falling edge
  task automatic step(input logic d, input logic s, input logic e);
    bus.din    = d;
    bus.sof    = s;
    bus.din_en = e;
    @(negedge clk);
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
  endtask

  // Send bits [first:last] of a word; sof on bit 0, optional idle gap between bits
  task automatic send_bits(input logic [15:0] w, input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      step(w[i], (i == 0), 1'b1);
      if (gap && i != last) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    fe_cnt     = 0;
    ov_cnt     = 0;
    rst_n      = 1'b0;
    bus.din    = 1'b0;
    bus.din_en = 1'b0;
    bus.sof    = 1'b0;
    bus.dout_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_dout", 32'(bus.dout), 32'h0);
    check_eq("rst_valid", 32'(bus.dout_valid), 32'h0);
    check_eq("rst_ferr", 32'(bus.frame_err), 32'h0);
    check_eq("rst_ovr", 32'(bus.overrun), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: continuous bits, ready high
    clear_counts();
    bus.dout_ready = 1'b1;
    send_bits(16'hA5C3, 0, 14, 1'b0);
    check_eq("t1_valid_before_last", 32'(bus.dout_valid), 32'h0);
    send_bits(16'hA5C3, 15, 15, 1'b0);
    check_eq("t1_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("t1_dout", 32'(bus.dout), 32'hA5C3);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t1_valid_drop", 32'(bus.dout_valid), 32'h0);
    check_eq("t1_ferr_cnt", 32'(fe_cnt), 32'h0);
    check_eq("t1_ovr_cnt", 32'(ov_cnt), 32'h0);

    // 2: junk bits ignored, din_en toggling
    clear_counts();
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    send_bits(16'hA5C3, 0, 15, 1'b1);
    check_eq("t2_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("t2_dout", 32'(bus.dout), 32'hA5C3);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t2_valid_drop", 32'(bus.dout_valid), 32'h0);
    check_eq("t2_ferr_cnt", 32'(fe_cnt), 32'h0);

    // 3: partial word then resync
    clear_counts();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_eq("t3_no_ferr_yet", 32'(fe_cnt), 32'h0);
    send_bits(16'h1234, 0, 0, 1'b0);
    check_eq("t3_ferr_pulse", 32'(bus.frame_err), 32'h1);
    send_bits(16'h1234, 1, 1, 1'b0);
    check_eq("t3_ferr_one_cycle", 32'(bus.frame_err), 32'h0);
    send_bits(16'h1234, 2, 15, 1'b0);
    check_eq("t3_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("t3_dout", 32'(bus.dout), 32'h1234);
    check_eq("t3_ferr_cnt", 32'(fe_cnt), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t3_valid_drop", 32'(bus.dout_valid), 32'h0);

    // 4: overrun while slot full
    clear_counts();
    bus.dout_ready = 1'b0;
    send_bits(16'hFFFF, 0, 15, 1'b0);
    check_eq("t4_valid_first", 32'(bus.dout_valid), 32'h1);
    check_eq("t4_dout_first", 32'(bus.dout), 32'hFFFF);
    send_bits(16'h0001, 0, 15, 1'b0);
    check_eq("t4_ovr_pulse", 32'(bus.overrun), 32'h1);
    check_eq("t4_dout_held", 32'(bus.dout), 32'hFFFF);
    check_eq("t4_valid_held", 32'(bus.dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t4_ovr_one_cycle", 32'(bus.overrun), 32'h0);
    check_eq("t4_ovr_cnt", 32'(ov_cnt), 32'h1);
    bus.dout_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_eq("t4_valid_drop", 32'(bus.dout_valid), 32'h0);

    // 5: new word loads on the same edge as a transfer
    clear_counts();
    bus.dout_ready = 1'b0;
    send_bits(16'h00FF, 0, 15, 1'b0);
    check_eq("t5_dout_first", 32'(bus.dout), 32'h00FF);
    send_bits(16'hBEEF, 0, 14, 1'b0);
    check_eq("t5_dout_stable", 32'(bus.dout), 32'h00FF);
    bus.dout_ready = 1'b1;
    send_bits(16'hBEEF, 15, 15, 1'b0);
    check_eq("t5_dout", 32'(bus.dout), 32'hBEEF);
    check_eq("t5_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("t5_ovr_cnt", 32'(ov_cnt), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("t5_valid_drop", 32'(bus.dout_valid), 32'h0);

    // 6: async reset mid-word, with a stale word still flagged in the slot
    clear_counts();
    bus.dout_ready = 1'b0;
    send_bits(16'h5A5A, 0, 15, 1'b0);
    send_bits(16'h0F0F, 0, 7, 1'b0);
    check_eq("t6_valid_pre", 32'(bus.dout_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_dout", 32'(bus.dout), 32'h0);
    check_eq("t6_rst_valid", 32'(bus.dout_valid), 32'h0);
    check_eq("t6_rst_ferr", 32'(bus.frame_err), 32'h0);
    check_eq("t6_rst_ovr", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dout_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    send_bits(16'h8001, 0, 15, 1'b0);
    check_eq("t6_valid", 32'(bus.dout_valid), 32'h1);
    check_eq("t6_dout", 32'(bus.dout), 32'h8001);
    check_eq("t6_err_cnt", 32'(fe_cnt + ov_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_in_par_out.md
# ser_in_par_out

Serial-in parallel-out deserializer: the receive end of the team's LSB-first 16-bit serial word link, mirroring the parallel-in serial-out shifter on the transmit side. It collects qualified serial bits, framed by a start-of-word marker, into a WIDTH-bit word. It presents each completed word on a ready/valid output port and flags framing errors and overruns.

## Interface
- `WIDTH`, default 16: word length in bits. Legal values are ≥ 2.

Ports:
- `clk`  input  1: single clock; all logic is rising-edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `din`  input  1: serial data bit. Sampled only when `din_en`=1.
- `din_en`  input  1: bit qualifier. Each cycle with `din_en`=1 carries exactly one bit.
- `sof`  input  1: start of frame. Meaningful only when `din_en`=1; marks the current bit as bit 0 (LSB) of a new word.
- `dout`  output  WIDTH: received word, LSB = first bit received.
- `dout_valid`  output  1: `dout` holds an unconsumed word.
- `dout_ready`  input  1: consumer accepts the word.
- `frame_err`  output  1: one-cycle pulse when a partial word is discarded by a `sof`.
- `overrun`  output  1: one-cycle pulse when a completed word is dropped because the output slot is full.

## Operation
- Reset (async, `rst_n`=0):
  - Shift register and `dout` clear to 0.
  - Bit counter clears to 0; state goes to IDLE.
  - `dout_valid`, `frame_err` and `overrun` are 0.
  - A partial word in progress is lost.
- State IDLE:
  - `din_en`=1 with `sof`=1: shift in `din`, set counter to 1, go to SHIFT.
  - `din_en`=1 with `sof`=0: bit is ignored.
- State SHIFT:
  - On `din_en`=1, shift right: sh <= {`din`, sh[WIDTH-1:1]}, counter +1.
  - `din_en`=0: hold state, shift register and counter.
- Resync: `din_en`=1 and `sof`=1 while in SHIFT (counter ≥ 1):
  - Discard the partial word.
  - Pulse `frame_err` for one cycle.
  - Treat the current bit as bit 0: counter = 1, stay in SHIFT.
- Completion: `din_en`=1, `sof`=0, counter = WIDTH-1:
  - Completed word = {`din`, sh[WIDTH-1:1]}.
  - Go to IDLE, counter = 0.
- Output slot is free if `dout_valid`=0, or if `dout_valid`=1 and `dout_ready`=1 in the same cycle.
  - Slot free: load the word into `dout`; `dout_valid`=1.
  - Slot not free: drop the word, pulse `overrun` for one cycle; `dout`/`dout_valid` are unchanged.
- Handshake: a transfer occurs on an edge where `dout_valid`=1 and `dout_ready`=1. After it, `dout_valid` falls unless a new word loads on the same edge.
- `dout` is stable while `dout_valid`=1 and `dout_ready`=0.
- `dout_ready` while `dout_valid`=0 has no effect.
- Counter width is $clog2(WIDTH+1) bits; it never exceeds WIDTH-1.

## Timing
- Latency: `dout_valid` rises at the clock edge that samples the WIDTH-th bit; `dout` is visible the following cycle.
- Minimum word period is WIDTH cycles with `din_en` held at 1. Back-to-back words with no gap are supported; `sof` accompanies bit 0 of the next word.
- Throughput: one word per WIDTH cycles, sustained when `dout_ready`=1.
- `frame_err` and `overrun` are registered and go high for exactly the cycle after the causing edge.
- Reset is asynchronous and all outputs clear immediately; reset deassertion is synchronized externally.

## Test plan
1. Send 16'hA5C3 LSB-first, `sof` on bit 0, `din_en`=1 continuously, `dout_ready`=1 → `dout`=16'hA5C3; `dout_valid` high exactly one cycle, starting the cycle after the 16th bit; no error pulses.
2. Same word with `din_en` toggling 1/0 every cycle, plus 3 junk bits with `sof`=0 sent beforehand → `dout`=16'hA5C3; junk is ignored.
3. Send 5 bits with `sof`, then 16'h1234 starting with `sof` → `frame_err` pulses once at the 6th `sof`-bit; `dout`=16'h1234.
4. `dout_ready`=0, then send 16'hFFFF followed by 16'h0001 → `dout` holds 16'hFFFF; `overrun` pulses once at completion of 16'h0001. Raise `dout_ready` → 16'hFFFF is transferred and `dout_valid` falls.
5. `dout_valid`=1 holding 16'h00FF, with `dout_ready`=1 on the same edge that 16'hBEEF completes → `dout`=16'hBEEF, `dout_valid` stays 1, no `overrun`.
6. Assert `rst_n`=0 mid-word after 8 bits → all outputs are 0 asynchronously. After release, a full 16'h8001 word yields `dout`=16'h8001.
